// File: rtl/dio_access_unit.sv
// Data/IO access unit: turns CPU load/store strobes into one handshaked bus cycle and stalls the pipeline meanwhile.
// Optional macro DIO_TIMEOUT_EN adds a TIMEOUT_CYCLES abort with a one-cycle bus_err pulse.
module dio_access_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_ren,
  input  logic        data_wren,
  input  logic        IO_ren,
  input  logic        IO_wren,
  input  logic [31:0] data_address,
  input  logic [15:0] IO_address,
  input  logic [15:0] wr_data,
  output logic [15:0] DIO_in,
  output logic        data_hazard,
  output logic        bus_req,
  output logic        bus_we,
  output logic        bus_io,
  output logic [31:0] bus_addr,
  output logic [15:0] bus_wdata,
  input  logic [15:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_any_strobe;
  logic        w_ack;
  logic        w_timeout;
  logic        w_launch;
  logic        r_we;
  logic        r_io;
  logic [31:0] r_addr;
  logic [15:0] r_wdata;
  logic [15:0] r_dio;

  assign w_any_strobe = data_wren | data_ren | IO_wren | IO_ren;
  assign w_launch     = (r_state == S_IDLE) && w_any_strobe;
  assign w_ack        = (r_state == S_REQ) && bus_ack;

`ifdef DIO_TIMEOUT_EN
  localparam logic [7:0] LP_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] r_cnt;
  logic       r_err;

  // r_cnt holds the number of ack-less REQ cycles already seen, so the abort fires on the TIMEOUT_CYCLES-th one
  assign w_timeout = (r_state == S_REQ) && !bus_ack && (r_cnt == LP_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= 8'd0;
      r_err <= 1'b0;
    end else begin
      r_err <= w_timeout;
      if ((r_state == S_REQ) && !bus_ack && !w_timeout)
        r_cnt <= r_cnt + 8'd1;
      else
        r_cnt <= 8'd0;
    end
  end

  assign bus_err = r_err;
`else
  assign w_timeout = 1'b0;
  assign bus_err   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any_strobe) w_next = S_REQ;
      S_REQ:   if (w_ack || w_timeout) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus_req     = (r_state == S_REQ);
    data_hazard = w_launch || (r_state == S_REQ);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_io    <= 1'b0;
      r_addr  <= 32'h0000_0000;
      r_wdata <= 16'h0000;
      r_dio   <= 16'h0000;
    end else begin
      if (w_launch) begin
        r_wdata <= wr_data;
        if (data_wren) begin
          r_we   <= 1'b1;
          r_io   <= 1'b0;
          r_addr <= data_address;
        end else if (data_ren) begin
          r_we   <= 1'b0;
          r_io   <= 1'b0;
          r_addr <= data_address;
        end else if (IO_wren) begin
          r_we   <= 1'b1;
          r_io   <= 1'b1;
          r_addr <= {16'h0000, IO_address};
        end else begin
          r_we   <= 1'b0;
          r_io   <= 1'b1;
          r_addr <= {16'h0000, IO_address};
        end
      end
      if (w_ack && !r_we)
        r_dio <= bus_rdata;
      else if (w_timeout && !r_we)
        r_dio <= 16'hFFFF;
    end
  end

  assign bus_we    = r_we;
  assign bus_io    = r_io;
  assign bus_addr  = r_addr;
  assign bus_wdata = r_wdata;
  assign DIO_in    = r_dio;

endmodule

// File: doc/dio_access_unit.md
DIO_ACCESS_UNIT -- requirements
Module: dio_access_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, is the number of REQ cycles without ack before abort; range 1..255, 8-bit counter.
REQ-002 clk  input  1  single clock; all state changes on posedge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 data_ren, data_wren, IO_ren, IO_wren  input  1 each  access strobes from the CPU execute stage.
REQ-005 data_address  input  32  data-space address; IO_address  input  16  IO-space address.
REQ-006 wr_data  input  16  store data.
REQ-007 DIO_in  output  16  registered read-return data to the register file.
REQ-008 data_hazard  output  1  pipeline stall request.
REQ-009 bus_req  output  1; bus_we  output  1; bus_io  output  1 (1 = IO space); bus_addr  output  32; bus_wdata  output  16.
REQ-010 bus_rdata  input  16; bus_ack  input  1; bus_err  output  1  timeout pulse.

Function
REQ-011 The FSM SHALL have states IDLE, REQ and DONE.
REQ-012 In IDLE with any strobe high, the block SHALL select one access by priority data_wren > data_ren > IO_wren > IO_ren, drop the others, latch address, space, direction and wr_data, and enter REQ.
REQ-013 An IO address SHALL be zero-extended to 32 bits on bus_addr.
REQ-014 data_hazard SHALL equal (IDLE and any strobe) or REQ, combinationally.
REQ-015 bus_req SHALL be high exactly while in REQ; bus_addr, bus_we, bus_io and bus_wdata SHALL be stable throughout REQ.
REQ-016 In REQ, bus_ack=1 SHALL move the FSM to DONE; on a read, bus_rdata SHALL be captured into DIO_in on that edge.
REQ-017 DONE SHALL last exactly one cycle with data_hazard low, ignore all strobes (they belong to the completed instruction), and return to IDLE.
REQ-018 Latency: strobe at cycle T; bus_req from T+1; ack sampled at cycle A; DIO_in valid and hazard low at A+1; next access accepted at A+2.
REQ-019 DIO_in SHALL hold its value until the next read completes; writes SHALL NOT alter it.
REQ-020 bus_ack SHALL be ignored in IDLE and DONE.
REQ-021 A strobe held high across IDLE SHALL launch exactly one bus cycle.

Reset
REQ-022 Asserting rst SHALL asynchronously force IDLE, with bus_req, bus_we, bus_io and bus_err at 0, bus_addr and bus_wdata at 0, DIO_in at 16'h0000, and the timeout counter at 0, including during an active REQ.
REQ-023 After rst deasserts, the first access SHALL start normally, with no residual ack from an aborted cycle taking effect.

Configuration
REQ-024 With DIO_TIMEOUT_EN defined, the counter SHALL increment each REQ cycle without ack; on reaching TIMEOUT_CYCLES the FSM SHALL go to DONE, DIO_in SHALL be 16'hFFFF on a read, and bus_err SHALL pulse high for one cycle.
REQ-025 Without DIO_TIMEOUT_EN, REQ SHALL wait indefinitely, bus_err SHALL be tied to 0, and no counter SHALL be instantiated.

Verification
REQ-026 data_ren with data_address=32'h0001_2340, ack after 3 cycles with bus_rdata=16'hBEEF -> bus_req high 3 cycles, bus_io=0, DIO_in=16'hBEEF at ack+1, hazard low at ack+1.
REQ-027 IO_wren with IO_address=16'h00A5 and wr_data=16'h1234, ack immediately -> bus_addr=32'h0000_00A5, bus_we=1, bus_io=1, bus_wdata=16'h1234, DIO_in unchanged.
REQ-028 data_wren and IO_ren asserted together -> one write bus cycle only, IO_ren dropped.
REQ-029 rst asserted mid-REQ -> bus_req low immediately with no clock edge, state IDLE, DIO_in=0; a following data_ren completes normally.
REQ-030 With DIO_TIMEOUT_EN and TIMEOUT_CYCLES=4, a read with no ack -> after 4 REQ cycles, DIO_in=16'hFFFF, bus_err pulses once, hazard drops; without the macro, bus_req stays high for 1000 cycles.
